axi3_ocm_slave: RTL and testbench
=================================

// Module: axi3_ocm_slave
// PURPOSE
//  AXI3 slave responder with on-chip word memory: the far end of the HP-port bursts issued by
//  the stream-to-AXI / AXI-to-stream controllers. Accepts INCR bursts of 1..16 32-bit beats,
//  writes with byte strobes, serves reads, and returns OKAY/SLVERR per burst. Serves as the
//  bench/OCM-substitute target for the AXI2S datapath and as a PL-side scratch buffer.
// PARAMETERS
//  BASE_ADDR  32'hfffc0000  byte address of word 0; window = BASE_ADDR .. BASE_ADDR+4*2^ADDR_W-1
//  ADDR_W     12            log2 of memory depth in 32-bit words
//  ID_W       6             AXI ID width
// PORTS
//  AXI_clk     in   1       sole clock
//  rst         in   1       asynchronous reset, active-low
//  AXI_awaddr  in   32      write burst start byte address
//  AXI_awid    in   ID_W    write ID, echoed on AXI_bid
//  AXI_awlen   in   4       beats-1
//  AXI_awsize  in   3       must be 3'b010
//  AXI_awburst in   2       must be 2'b01 (INCR)
//  AXI_awvalid in 1 / AXI_awready out 1   AW handshake
//  AXI_wdata   in   32      write data
//  AXI_wstrb   in   4       byte enables, bit n -> wdata[8n+7:8n]
//  AXI_wid     in   ID_W    must equal captured awid
//  AXI_wlast   in   1       final write beat marker
//  AXI_wvalid  in 1 / AXI_wready out 1    W handshake
//  AXI_bid out ID_W; AXI_bresp out 2; AXI_bvalid out 1; AXI_bready in 1   B channel
//  AXI_araddr/arid/arlen/arsize/arburst  in  32/ID_W/4/3/2  read burst, same rules as AW
//  AXI_arvalid in 1 / AXI_arready out 1   AR handshake
//  AXI_rdata out 32; AXI_rid out ID_W; AXI_rresp out 2; AXI_rlast out 1
//  AXI_rvalid out 1 / AXI_rready in 1     R handshake
//  err_sticky  out  1       set on any SLVERR response, cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0 while rst low; FSMs to IDLE; memory contents NOT cleared. awready and
//   arready rise on the first AXI_clk edge after rst deasserts. Reset mid-burst abandons it.
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE; read FSM R_IDLE -> R_FETCH -> R_DATA. Independent.
//  W_IDLE: awready=1. On awvalid&awready capture id, len, word index=(awaddr-BASE_ADDR)>>2,
//   err = start or end (awaddr+4*awlen) outside window | awsize!=010 | awburst!=01. -> W_DATA.
//  W_DATA: wready=1; beat counter 0..len. Each accepted beat: if !err write strobed bytes at
//   index, index+1. wid!=awid or wlast!=(count==len) sets err (all len+1 beats still accepted,
//   no early termination). Beat count==len accepted -> W_RESP.
//  W_RESP: bvalid=1, bid=captured id, bresp = err ? 2'b10 : 2'b00; held stable until bready.
//  R_IDLE: arready=1. On handshake capture as for AW -> R_FETCH. R_FETCH: synchronous memory
//   read of index -> R_DATA. R_DATA: rvalid=1, rid, rdata (32'h0 if err), rresp per err,
//   rlast=(count==len); all held stable while rready low. On rvalid&rready: last -> R_IDLE,
//   else index+1 -> R_FETCH. First rvalid 2 cycles after AR handshake; 1 beat per 2 cycles.
//  Same-cycle write and fetch of one word: fetch returns old data (read-before-write).
//  awaddr[1:0]/araddr[1:0] ignored (word aligned). Index arithmetic ADDR_W bits; never wraps
//   in an accepted OKAY burst because end address is checked at capture.
//  err_sticky set on cycle bvalid or rvalid is first asserted with SLVERR.
// TESTING
//  16-beat write at BASE_ADDR, data 0..15, wstrb F, awid 6'h3F -> bresp 00, bid 3F; 16-beat
//   read there -> rdata 0..15, rlast on beat 16 only, rresp 00, rid echoes arid.
//  Word=32'h11223344, write 32'hAABBCCDD wstrb 4'b0011 -> read returns 32'h1122CCDD.
//  AR at BASE_ADDR+4*2^ADDR_W, len 15 -> 16 beats rdata 0, rresp 10, rlast on 16th, err_sticky=1.
//  rready low 5 cycles on beat 7 -> rvalid/rdata/rlast stable; all 16 beats delivered in order.
//  len 15 write with wlast on beat 8 -> 16 beats accepted, bresp 10, memory unchanged.
//  rst low during beat 5 of write -> outputs 0, FSMs idle; words 0..4 retained; next burst OKAY.

Source files
------------

// File: rtl/axi3_ocm_slave.sv
// AXI3 slave with an on-chip 32-bit word memory.
// - Accepts INCR bursts of 1..16 beats, with byte-strobed writes.
// - Returns OKAY or SLVERR once per burst.
// - The write and read channels run as two independent FSMs that share one memory array.
module axi3_ocm_slave #(
  parameter logic [31:0] BASE_ADDR = 32'hfffc0000,
  parameter int          ADDR_W    = 12,
  parameter int          ID_W      = 6
) (
  input  logic              AXI_clk,
  input  logic              rst,
  // write address
  input  logic [31:0]       AXI_awaddr,
  input  logic [ID_W-1:0]   AXI_awid,
  input  logic [3:0]        AXI_awlen,
  input  logic [2:0]        AXI_awsize,
  input  logic [1:0]        AXI_awburst,
  input  logic              AXI_awvalid,
  output logic              AXI_awready,
  // write data
  input  logic [31:0]       AXI_wdata,
  input  logic [3:0]        AXI_wstrb,
  input  logic [ID_W-1:0]   AXI_wid,
  input  logic              AXI_wlast,
  input  logic              AXI_wvalid,
  output logic              AXI_wready,
  // write response
  output logic [ID_W-1:0]   AXI_bid,
  output logic [1:0]        AXI_bresp,
  output logic              AXI_bvalid,
  input  logic              AXI_bready,
  // read address
  input  logic [31:0]       AXI_araddr,
  input  logic [ID_W-1:0]   AXI_arid,
  input  logic [3:0]        AXI_arlen,
  input  logic [2:0]        AXI_arsize,
  input  logic [1:0]        AXI_arburst,
  input  logic              AXI_arvalid,
  output logic              AXI_arready,
  // read data
  output logic [31:0]       AXI_rdata,
  output logic [ID_W-1:0]   AXI_rid,
  output logic [1:0]        AXI_rresp,
  output logic              AXI_rlast,
  output logic              AXI_rvalid,
  input  logic              AXI_rready,
  output logic              err_sticky
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  // Byte offset from the window base, word aligned.
  // The extra top bit makes addresses below the base come out huge instead of small.
  function automatic logic [32:0] byte_offset(input logic [31:0] addr);
    return {1'b0, addr & 32'hffff_fffc} - {1'b0, BASE_ADDR};
  endfunction

  // A burst is rejected when any of these holds:
  // - its first or last beat falls outside the window;
  // - it is not 32-bit;
  // - it is not INCR.
  function automatic logic burst_err(input logic [32:0] start_off, input logic [3:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [32:0] end_off;
    end_off = start_off + {27'd0, len, 2'b00};
    return (start_off >= WIN_BYTES) || (end_off >= WIN_BYTES) ||
           (size != 3'b010) || (burst != 2'b01);
  endfunction

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;

  logic        ready_en_q, ready_en_d;
  logic        err_sticky_q, err_sticky_d;

  w_state_e    w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [3:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [ADDR_W-1:0] w_idx_q, w_idx_d;
  logic              w_err_q, w_err_d;
  logic              beat_err, mem_we;

  r_state_e    r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [3:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [ADDR_W-1:0] r_idx_q, r_idx_d;
  logic              r_err_q, r_err_d;
  logic              r_fetch;

  logic [32:0] aw_off, ar_off;
  assign aw_off = byte_offset(AXI_awaddr);
  assign ar_off = byte_offset(AXI_araddr);

  // Channel outputs: all are decoded from reset flops, so they are low while rst is low.
  assign AXI_awready = ready_en_q && (w_state_q == W_IDLE);
  assign AXI_wready  = (w_state_q == W_DATA);
  assign AXI_bvalid  = (w_state_q == W_RESP);
  assign AXI_bid     = w_id_q;
  assign AXI_bresp   = (AXI_bvalid && w_err_q) ? 2'b10 : 2'b00;
  assign AXI_arready = ready_en_q && (r_state_q == R_IDLE);
  assign AXI_rvalid  = (r_state_q == R_DATA);
  assign AXI_rid     = r_id_q;
  assign AXI_rdata   = (AXI_rvalid && !r_err_q) ? rd_q : 32'h0;
  assign AXI_rresp   = (AXI_rvalid && r_err_q) ? 2'b10 : 2'b00;
  assign AXI_rlast   = AXI_rvalid && (r_cnt_q == r_len_q);
  assign err_sticky  = err_sticky_q;

  // State registers for both FSMs, the post-reset ready enable and the sticky error.
  always_ff @(posedge AXI_clk or negedge rst) begin
    if (!rst) begin
      ready_en_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      w_state_q    <= W_IDLE;
      w_id_q       <= '0;
      w_len_q      <= '0;
      w_cnt_q      <= '0;
      w_idx_q      <= '0;
      w_err_q      <= 1'b0;
      r_state_q    <= R_IDLE;
      r_id_q       <= '0;
      r_len_q      <= '0;
      r_cnt_q      <= '0;
      r_idx_q      <= '0;
      r_err_q      <= 1'b0;
    end else begin
      ready_en_q   <= ready_en_d;
      err_sticky_q <= err_sticky_d;
      w_state_q    <= w_state_d;
      w_id_q       <= w_id_d;
      w_len_q      <= w_len_d;
      w_cnt_q      <= w_cnt_d;
      w_idx_q      <= w_idx_d;
      w_err_q      <= w_err_d;
      r_state_q    <= r_state_d;
      r_id_q       <= r_id_d;
      r_len_q      <= r_len_d;
      r_cnt_q      <= r_cnt_d;
      r_idx_q      <= r_idx_d;
      r_err_q      <= r_err_d;
    end
  end

  // Write FSM next state: capture the AW command, accept len+1 beats, then hold the response.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_idx_d   = w_idx_q;
    w_err_d   = w_err_q;
    beat_err  = 1'b0;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (AXI_awvalid && AXI_awready) begin
          w_id_d    = AXI_awid;
          w_len_d   = AXI_awlen;
          w_cnt_d   = '0;
          w_idx_d   = aw_off[ADDR_W+1:2];
          w_err_d   = burst_err(aw_off, AXI_awlen, AXI_awsize, AXI_awburst);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (AXI_wvalid) begin
          // A protocol error on a beat suppresses that beat and every later beat.
          // The burst is still drained to its full length.
          beat_err  = (AXI_wid != w_id_q) || (AXI_wlast != (w_cnt_q == w_len_q));
          w_err_d   = w_err_q || beat_err;
          mem_we    = !w_err_d;
          w_idx_d   = w_idx_q + 1'b1;
          w_cnt_d   = w_cnt_q + 1'b1;
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (AXI_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next state: fetch one word, present it, and repeat until the last beat is taken.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_idx_d   = r_idx_q;
    r_err_d   = r_err_q;
    r_fetch   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (AXI_arvalid && AXI_arready) begin
          r_id_d    = AXI_arid;
          r_len_d   = AXI_arlen;
          r_cnt_d   = '0;
          r_idx_d   = ar_off[ADDR_W+1:2];
          r_err_d   = burst_err(ar_off, AXI_arlen, AXI_arsize, AXI_arburst);
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        r_fetch   = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (AXI_rready) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_idx_d   = r_idx_q + 1'b1;
            r_cnt_d   = r_cnt_q + 1'b1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Sticky error latches in the same cycle an SLVERR response first becomes visible.
  always_comb begin
    ready_en_d   = 1'b1;
    err_sticky_d = err_sticky_q;
    if ((w_state_q == W_DATA) && (w_state_d == W_RESP) && w_err_d) err_sticky_d = 1'b1;
    if ((r_state_q == R_FETCH) && r_err_q) err_sticky_d = 1'b1;
  end

  // Memory array: byte-strobed write port and registered read port.
  // NOTE: the array is deliberately not reset; contents survive rst.
  // NOTE: both ports update with <=, so a same-cycle fetch of a word being written returns its old value.
  always_ff @(posedge AXI_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (AXI_wstrb[b]) mem[w_idx_q][8*b +: 8] <= AXI_wdata[8*b +: 8];
      end
    end
    if (r_fetch) rd_q <= mem[r_idx_q];
  end

endmodule

// File: tb/tb_axi3_ocm_slave.sv
// Self-checking bench for axi3_ocm_slave.
// Randomized AXI3 bursts are compared against a word-array model of the memory.
// The model applies the window, size, burst, wid and wlast rules.
module tb_axi3_ocm_slave;

  localparam logic [31:0] BASE   = 32'hfffc0000;
  localparam int          ADDR_W = 12;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam int          ID_W   = 6;

  logic clk, rst_n;
  logic [31:0] AXI_awaddr, AXI_araddr, AXI_wdata, AXI_rdata;
  logic [ID_W-1:0] AXI_awid, AXI_wid, AXI_bid, AXI_arid, AXI_rid;
  logic [3:0] AXI_awlen, AXI_arlen, AXI_wstrb;
  logic [2:0] AXI_awsize, AXI_arsize;
  logic [1:0] AXI_awburst, AXI_arburst, AXI_bresp, AXI_rresp;
  logic AXI_awvalid, AXI_awready, AXI_wlast, AXI_wvalid, AXI_wready, AXI_bvalid, AXI_bready;
  logic AXI_arvalid, AXI_arready, AXI_rlast, AXI_rvalid, AXI_rready, err_sticky;

  axi3_ocm_slave #(.BASE_ADDR(BASE), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .AXI_clk(clk), .rst(rst_n),
    .AXI_awaddr(AXI_awaddr), .AXI_awid(AXI_awid), .AXI_awlen(AXI_awlen),
    .AXI_awsize(AXI_awsize), .AXI_awburst(AXI_awburst),
    .AXI_awvalid(AXI_awvalid), .AXI_awready(AXI_awready),
    .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb), .AXI_wid(AXI_wid), .AXI_wlast(AXI_wlast),
    .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready),
    .AXI_bid(AXI_bid), .AXI_bresp(AXI_bresp), .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready),
    .AXI_araddr(AXI_araddr), .AXI_arid(AXI_arid), .AXI_arlen(AXI_arlen),
    .AXI_arsize(AXI_arsize), .AXI_arburst(AXI_arburst),
    .AXI_arvalid(AXI_arvalid), .AXI_arready(AXI_arready),
    .AXI_rdata(AXI_rdata), .AXI_rid(AXI_rid), .AXI_rresp(AXI_rresp), .AXI_rlast(AXI_rlast),
    .AXI_rvalid(AXI_rvalid), .AXI_rready(AXI_rready),
    .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory and per-burst scratch arrays.
  logic [31:0] mdl [DEPTH];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [5:0]  rd_id   [16];
  logic [31:0] exp_data [16];
  logic [1:0]  exp_resp;
  int          rd_lat;
  logic        rd_stable;
  logic [1:0]  b_resp;
  logic [5:0]  b_id;
  logic        b_sticky;

  task automatic timeout(input string what);
    n_tests++; n_fail++;
    $display("FAIL timeout waiting for %s", what);
  endtask

  // ---------------- reference model ----------------
  function automatic logic cap_err(input logic [31:0] addr, input int len,
                                   input logic [2:0] size, input logic [1:0] burst);
    longint a, lo, hi;
    a  = {32'h0, addr & 32'hffff_fffc};
    lo = {32'h0, BASE};
    hi = lo + 4 * DEPTH;
    return (a < lo) || (a + 4 * len >= hi) || (size != 3'b010) || (burst != 2'b01);
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr & 32'hffff_fffc) - BASE) / 4;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input int last_beat, input int bad_wid_beat);
    logic err;
    err = cap_err(addr, len, size, burst);
    for (int b = 0; b <= len; b++) begin
      err = err || (b == bad_wid_beat) || ((b == last_beat) != (b == len));
      if (!err)
        for (int k = 0; k < 4; k++)
          if (wr_strb[b][k]) mdl[word_of(addr) + b][8*k +: 8] = wr_data[b][8*k +: 8];
    end
    exp_resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic model_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst);
    logic err;
    err = cap_err(addr, len, size, burst);
    for (int b = 0; b <= len; b++) exp_data[b] = err ? 32'h0 : mdl[word_of(addr) + b];
    exp_resp = err ? 2'b10 : 2'b00;
  endtask

  // ---------------- bus drivers (drive and sample on the falling edge) ----------------
  task automatic idle_inputs();
    AXI_awaddr = '0; AXI_awid = '0; AXI_awlen = '0; AXI_awsize = '0; AXI_awburst = '0;
    AXI_awvalid = 0; AXI_wdata = '0; AXI_wstrb = '0; AXI_wid = '0; AXI_wlast = 0;
    AXI_wvalid = 0; AXI_bready = 0; AXI_araddr = '0; AXI_arid = '0; AXI_arlen = '0;
    AXI_arsize = '0; AXI_arburst = '0; AXI_arvalid = 0; AXI_rready = 0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [5:0] id, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int last_beat, input int bad_wid_beat);
    int n;
    @(negedge clk);
    AXI_awaddr = addr; AXI_awid = id; AXI_awlen = len; AXI_awsize = size; AXI_awburst = burst;
    AXI_awvalid = 1;
    n = 0;
    while (!AXI_awready) begin
      @(negedge clk); n++;
      if (n > 100) begin timeout("awready"); AXI_awvalid = 0; return; end
    end
    @(negedge clk);
    AXI_awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      AXI_wvalid = 0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      AXI_wvalid = 1; AXI_wdata = wr_data[b]; AXI_wstrb = wr_strb[b];
      AXI_wlast = (b == last_beat); AXI_wid = (b == bad_wid_beat) ? ~id : id;
      n = 0;
      while (!AXI_wready) begin
        @(negedge clk); n++;
        if (n > 100) begin timeout("wready"); AXI_wvalid = 0; return; end
      end
      @(negedge clk);
    end
    AXI_wvalid = 0; AXI_wlast = 0;
    n = 0;
    while (!AXI_bvalid) begin
      @(negedge clk); n++;
      if (n > 100) begin timeout("bvalid"); return; end
    end
    b_resp = AXI_bresp; b_id = AXI_bid; b_sticky = err_sticky;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    AXI_bready = 1;
    @(negedge clk);
    AXI_bready = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [5:0] id, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input int stall_cycles);
    int n, hold;
    @(negedge clk);
    AXI_araddr = addr; AXI_arid = id; AXI_arlen = len; AXI_arsize = size; AXI_arburst = burst;
    AXI_arvalid = 1;
    n = 0;
    while (!AXI_arready) begin
      @(negedge clk); n++;
      if (n > 100) begin timeout("arready"); AXI_arvalid = 0; return; end
    end
    rd_lat = 0;
    @(negedge clk);
    AXI_arvalid = 0;
    rd_lat = 1;
    while (!AXI_rvalid) begin
      @(negedge clk); rd_lat++;
      if (rd_lat > 100) begin timeout("first rvalid"); return; end
    end
    rd_stable = 1;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!AXI_rvalid) begin
        @(negedge clk); n++;
        if (n > 100) begin timeout("rvalid"); return; end
      end
      rd_data[b] = AXI_rdata; rd_resp[b] = AXI_rresp; rd_last[b] = AXI_rlast; rd_id[b] = AXI_rid;
      hold = (b == stall_beat) ? stall_cycles : int'($urandom_range(0, 1));
      repeat (hold) begin
        @(negedge clk);
        if ({AXI_rvalid, AXI_rdata, AXI_rlast, AXI_rresp, AXI_rid} !==
            {1'b1, rd_data[b], rd_last[b], rd_resp[b], rd_id[b]}) rd_stable = 0;
      end
      AXI_rready = 1;
      @(negedge clk);
      AXI_rready = 0;
    end
  endtask

  // Compare a completed read against the model.
  task automatic check_read(input string name, input int len, input logic [5:0] id);
    for (int b = 0; b <= len; b++) begin
      n_tests++;
      if ({rd_data[b], rd_resp[b], rd_last[b], rd_id[b]} !== {exp_data[b], exp_resp, 1'(b == len), id}) begin
        n_fail++;
        $display("FAIL %s beat %0d: got data %h resp %b last %b id %h, expected %h %b %b %h",
                 name, b, rd_data[b], rd_resp[b], rd_last[b], rd_id[b],
                 exp_data[b], exp_resp, b == len, id);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    n_tests++;
    if ({AXI_awready, AXI_wready, AXI_bvalid, AXI_bid, AXI_bresp, AXI_arready, AXI_rvalid,
         AXI_rdata, AXI_rid, AXI_rresp, AXI_rlast, err_sticky} !== '0) begin
      n_fail++; $display("FAIL reset outputs: some output not 0 during reset");
    end
    @(negedge clk); rst_n = 1; #1;
    n_tests++;
    if ({AXI_awready, AXI_arready} !== 2'b00) begin
      n_fail++; $display("FAIL reset ready early: got %b expected 00", {AXI_awready, AXI_arready});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({AXI_awready, AXI_arready} !== 2'b11) begin
      n_fail++; $display("FAIL reset ready after edge: got %b expected 11", {AXI_awready, AXI_arready});
    end
  endtask

  task automatic test_burst16();
    for (int b = 0; b < 16; b++) begin wr_data[b] = b; wr_strb[b] = 4'hf; end
    model_write(BASE, 15, 3'b010, 2'b01, 15, -1);
    do_write(BASE, 6'h3f, 4'd15, 3'b010, 2'b01, 15, -1);
    n_tests++;
    if ({b_resp, b_id} !== {2'b00, 6'h3f}) begin
      n_fail++; $display("FAIL burst16 bresp/bid: got %b/%h expected 00/3f", b_resp, b_id);
    end
    model_read(BASE, 15, 3'b010, 2'b01);
    for (int b = 0; b < 16; b++) begin
      n_tests++;
      if (exp_data[b] !== 32'(b)) begin
        n_fail++; $display("FAIL burst16 model word %0d: got %h expected %h", b, exp_data[b], b);
      end
    end
    do_read(BASE, 6'h15, 4'd15, 3'b010, 2'b01, -1, 0);
    n_tests++;
    if (rd_lat !== 2) begin
      n_fail++; $display("FAIL read latency: got %0d expected 2", rd_lat);
    end
    check_read("burst16 read", 15, 6'h15);
    // Initialise words 16..63 so later random reads have defined contents.
    for (int k = 1; k < 4; k++) begin
      for (int b = 0; b < 16; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hf; end
      model_write(BASE + 32'(64 * k), 15, 3'b010, 2'b01, 15, -1);
      do_write(BASE + 32'(64 * k), 6'(k), 4'd15, 3'b010, 2'b01, 15, -1);
      n_tests++;
      if (b_resp !== 2'b00) begin n_fail++; $display("FAIL fill bresp: got %b expected 00", b_resp); end
    end
  endtask

  task automatic test_strobe();
    logic [31:0] a;
    a = BASE + 32'd80;
    wr_data[0] = 32'h11223344; wr_strb[0] = 4'hf;
    model_write(a, 0, 3'b010, 2'b01, 0, -1);
    do_write(a, 6'h01, 4'd0, 3'b010, 2'b01, 0, -1);
    wr_data[0] = 32'haabbccdd; wr_strb[0] = 4'b0011;
    model_write(a, 0, 3'b010, 2'b01, 0, -1);
    do_write(a, 6'h02, 4'd0, 3'b010, 2'b01, 0, -1);
    do_read(a, 6'h03, 4'd0, 3'b010, 2'b01, -1, 0);
    n_tests++;
    if (rd_data[0] !== 32'h1122ccdd) begin
      n_fail++; $display("FAIL strobe merge: got %h expected 1122ccdd", rd_data[0]);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] top;
    top = BASE + 32'(4 * (DEPTH - 1));
    n_tests++;
    if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky before errors: got %b expected 0", err_sticky); end
    wr_data[0] = $urandom; wr_strb[0] = 4'hf;
    model_write(top, 0, 3'b010, 2'b01, 0, -1);
    do_write(top, 6'h05, 4'd0, 3'b010, 2'b01, 0, -1);
    n_tests++;
    if ({b_resp, err_sticky} !== 3'b000) begin
      n_fail++; $display("FAIL last word write: got resp %b sticky %b expected 00 0", b_resp, err_sticky);
    end
    // Read starting just past the window.
    model_read(BASE + 32'(4 * DEPTH), 15, 3'b010, 2'b01);
    do_read(BASE + 32'(4 * DEPTH), 6'h2a, 4'd15, 3'b010, 2'b01, -1, 0);
    check_read("oob read", 15, 6'h2a);
    n_tests++;
    if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky after oob read: got %b expected 1", err_sticky); end
    // Write whose end crosses the top of the window is refused entirely.
    for (int b = 0; b < 16; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hf; end
    model_write(top - 32'd20, 15, 3'b010, 2'b01, 15, -1);
    do_write(top - 32'd20, 6'h06, 4'd15, 3'b010, 2'b01, 15, -1);
    n_tests++;
    if ({b_resp, b_sticky} !== 3'b101) begin
      n_fail++; $display("FAIL crossing write: got resp %b sticky %b expected 10 1", b_resp, b_sticky);
    end
    model_read(top - 32'd20, 5, 3'b010, 2'b01);
    model_read(top - 32'd20, 0, 3'b010, 2'b01);
    for (int b = 0; b < 6; b++) exp_data[b] = mdl[DEPTH - 6 + b];
    exp_resp = 2'b00;
    do_read(top - 32'd20, 6'h07, 4'd5, 3'b010, 2'b01, -1, 0);
    check_read("crossing write left memory", 5, 6'h07);
    // Start below the base.
    model_read(BASE - 32'd4, 0, 3'b010, 2'b01);
    do_read(BASE - 32'd4, 6'h08, 4'd0, 3'b010, 2'b01, -1, 0);
    check_read("below base read", 0, 6'h08);
  endtask

  task automatic test_rready_stall();
    model_read(BASE, 15, 3'b010, 2'b01);
    do_read(BASE, 6'h11, 4'd15, 3'b010, 2'b01, 6, 5);
    n_tests++;
    if (rd_stable !== 1'b1) begin n_fail++; $display("FAIL stall stability: got %b expected 1", rd_stable); end
    check_read("stalled read", 15, 6'h11);
  endtask

  task automatic test_bad_wlast();
    logic [31:0] a;
    logic [31:0] snap [16];
    a = BASE + 32'd128;
    for (int b = 0; b < 16; b++) begin
      snap[b] = mdl[32 + b]; wr_data[b] = $urandom; wr_strb[b] = (b < 7) ? 4'h0 : 4'hf;
    end
    model_write(a, 15, 3'b010, 2'b01, 7, -1);
    do_write(a, 6'h09, 4'd15, 3'b010, 2'b01, 7, -1);
    n_tests++;
    if (b_resp !== 2'b10) begin n_fail++; $display("FAIL early wlast bresp: got %b expected 10", b_resp); end
    for (int b = 0; b < 16; b++) exp_data[b] = snap[b];
    exp_resp = 2'b00;
    do_read(a, 6'h0a, 4'd15, 3'b010, 2'b01, -1, 0);
    check_read("early wlast memory", 15, 6'h0a);
    // A wid mismatch on the third beat: first two beats land, the rest do not.
    for (int b = 0; b < 4; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hf; end
    model_write(a + 32'd64, 3, 3'b010, 2'b01, 3, 2);
    do_write(a + 32'd64, 6'h0b, 4'd3, 3'b010, 2'b01, 3, 2);
    n_tests++;
    if (b_resp !== 2'b10) begin n_fail++; $display("FAIL wid mismatch bresp: got %b expected 10", b_resp); end
    model_read(a + 32'd64, 3, 3'b010, 2'b01);
    do_read(a + 32'd64, 6'h0c, 4'd3, 3'b010, 2'b01, -1, 0);
    check_read("wid mismatch memory", 3, 6'h0c);
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int len, w;
      logic [31:0] a;
      logic [5:0] id;
      logic [2:0] size;
      logic [1:0] burst;
      len   = $urandom_range(0, 15);
      w     = $urandom_range(0, 63 - len);
      a     = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
      id    = 6'($urandom);
      size  = ($urandom_range(0, 7) == 0) ? 3'b011 : 3'b010;
      burst = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01;
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= len; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'($urandom); end
        model_write(a, len, size, burst, len, -1);
        do_write(a, id, 4'(len), size, burst, len, -1);
        n_tests++;
        if ({b_resp, b_id} !== {exp_resp, id}) begin
          n_fail++; $display("FAIL random write %0d: got %b/%h expected %b/%h", it, b_resp, b_id, exp_resp, id);
        end
      end else begin
        model_read(a, len, size, burst);
        do_read(a, id, 4'(len), size, burst, -1, 0);
        check_read("random read", len, id);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] a;
    int n;
    a = BASE + 32'd128;
    for (int b = 0; b < 16; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hf; end
    @(negedge clk);
    AXI_awaddr = a; AXI_awid = 6'h0d; AXI_awlen = 4'd15; AXI_awsize = 3'b010; AXI_awburst = 2'b01;
    AXI_awvalid = 1;
    n = 0;
    while (!AXI_awready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    AXI_awvalid = 0;
    for (int b = 0; b < 5; b++) begin
      AXI_wvalid = 1; AXI_wdata = wr_data[b]; AXI_wstrb = 4'hf; AXI_wid = 6'h0d; AXI_wlast = 0;
      n = 0;
      while (!AXI_wready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      mdl[32 + b] = wr_data[b];
    end
    AXI_wdata = wr_data[5];
    #2 rst_n = 0;
    #1;
    n_tests++;
    if ({AXI_awready, AXI_wready, AXI_bvalid, AXI_bid, AXI_bresp, AXI_arready, AXI_rvalid,
         AXI_rdata, AXI_rid, AXI_rresp, AXI_rlast, err_sticky} !== '0) begin
      n_fail++; $display("FAIL mid-write reset outputs: some output not 0 during reset");
    end
    @(negedge clk);
    AXI_wvalid = 0;
    #2 rst_n = 1;
    @(negedge clk);
    n_tests++;
    if ({AXI_awready, AXI_arready, AXI_wready, err_sticky} !== 4'b1100) begin
      n_fail++; $display("FAIL after reset state: got %b expected 1100",
                         {AXI_awready, AXI_arready, AXI_wready, err_sticky});
    end
    for (int b = 0; b < 2; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hf; end
    model_write(BASE + 32'd200, 1, 3'b010, 2'b01, 1, -1);
    do_write(BASE + 32'd200, 6'h0e, 4'd1, 3'b010, 2'b01, 1, -1);
    n_tests++;
    if (b_resp !== 2'b00) begin n_fail++; $display("FAIL post-reset burst bresp: got %b expected 00", b_resp); end
    model_read(a, 15, 3'b010, 2'b01);
    do_read(a, 6'h0f, 4'd15, 3'b010, 2'b01, -1, 0);
    check_read("retained after reset", 15, 6'h0f);
  endtask

  initial begin
    test_reset();
    test_burst16();
    test_strobe();
    test_rready_stall();
    test_boundary();
    test_bad_wlast();
    test_random();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
